// File: rtl/stdp_scheduler_if.sv
// Spike inputs and weight/update outputs of the STDP learning controller.
// The slave side is the scheduler; the master side drives spikes.
interface stdp_scheduler_if #(
  parameter int NUM_SYN = 4,
  parameter int IDX_W   = $clog2(NUM_SYN),
  parameter int W_W     = 16
);
  logic [NUM_SYN-1:0]     preSpike;
  logic                   postSpike;
  logic                   learn_en;
  logic [NUM_SYN*W_W-1:0] weight_bus;
  logic                   upd_valid;
  logic [IDX_W-1:0]       upd_idx;
  logic                   upd_ltp;
  logic                   busy;

  modport master (
    output preSpike, postSpike, learn_en,
    input  weight_bus, upd_valid, upd_idx, upd_ltp, busy
  );

  modport slave (
    input  preSpike, postSpike, learn_en,
    output weight_bus, upd_valid, upd_idx, upd_ltp, busy
  );
endinterface

// File: rtl/stdp_scheduler.sv
// STDP learning controller: spike-age timestamps, pairing classification,
// per-synapse pending queue and a round-robin serialised weight update.
module stdp_scheduler #(
  parameter int NUM_SYN = 4,
  parameter int IDX_W   = $clog2(NUM_SYN),
  parameter int W_W     = 16,
  parameter int AGE_W   = 4,
  parameter int WIN     = 8,
  parameter int DELW    = 12,
  parameter logic [W_W-1:0] WMAX = 16'hFFFF
) (
  input logic              clk,
  input logic              reset,
  stdp_scheduler_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_UPDATE
  } state_e;

  localparam int WX = W_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] WIN_A   = AGE_W'(WIN);
  localparam logic [WX-1:0]    DELW_X  = WX'(DELW);
  localparam logic [WX-1:0]    WMAX_X  = {1'b0, WMAX};
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_SYN - 1);

  state_e st_q, st_d;

  logic [AGE_W-1:0] pre_age_q [NUM_SYN];
  logic [AGE_W-1:0] pre_age_d [NUM_SYN];
  logic [AGE_W-1:0] post_age_q, post_age_d;

  logic [W_W-1:0] w_q [NUM_SYN];
  logic [W_W-1:0] w_d [NUM_SYN];

  logic [NUM_SYN-1:0] pend_q, pend_d;
  logic [NUM_SYN-1:0] dir_q, dir_d;
  logic [NUM_SYN-1:0] req, req_ltp;

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ltp_q, ltp_d;
  logic [IDX_W-1:0] grant;
  logic             found;

  logic [WX-1:0]  w_ext, w_sum, w_dif;
  logic [W_W-1:0] w_new;

  always_comb begin
    for (int i = 0; i < NUM_SYN; i++) begin
      if (bus.preSpike[i])
        pre_age_d[i] = '0;
      else if (pre_age_q[i] == AGE_MAX)
        pre_age_d[i] = AGE_MAX;
      else
        pre_age_d[i] = pre_age_q[i] + 1'b1;
    end
    if (bus.postSpike)
      post_age_d = '0;
    else if (post_age_q == AGE_MAX)
      post_age_d = AGE_MAX;
    else
      post_age_d = post_age_q + 1'b1;
  end

  // Pre spike is checked first so coincident spikes resolve to LTD.
  always_comb begin
    req     = '0;
    req_ltp = '0;
    if (bus.learn_en) begin
      for (int i = 0; i < NUM_SYN; i++) begin
        if (bus.preSpike[i] && (post_age_q < WIN_A)) begin
          req[i] = 1'b1;
        end else if (bus.postSpike && (pre_age_q[i] < WIN_A)) begin
          req[i]     = 1'b1;
          req_ltp[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SYN; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_SYN)
        j = j - NUM_SYN;
      if (!found && pend_q[j]) begin
        found = 1'b1;
        grant = IDX_W'(j);
      end
    end
  end

  always_comb begin
    w_ext = {1'b0, w_q[idx_q]};
    w_sum = w_ext + DELW_X;
    w_dif = w_ext - DELW_X;
    if (ltp_q)
      w_new = (w_sum > WMAX_X) ? WMAX : w_sum[W_W-1:0];
    else
      w_new = w_dif[W_W] ? '0 : w_dif[W_W-1:0];
  end

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    ltp_d  = ltp_q;
    rr_d   = rr_q;
    pend_d = pend_q;
    dir_d  = dir_q;
    w_d    = w_q;
    unique case (st_q)
      S_IDLE: begin
        if (found) begin
          idx_d = grant;
          ltp_d = dir_q[grant];
          st_d  = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_d[idx_q]    = w_new;
        pend_d[idx_q] = 1'b0;
        rr_d          = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        st_d          = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
    // A request on the service edge re-arms the entry with its new direction.
    for (int i = 0; i < NUM_SYN; i++) begin
      if (req[i]) begin
        pend_d[i] = 1'b1;
        dir_d[i]  = req_ltp[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q       <= S_IDLE;
      post_age_q <= AGE_MAX;
      pend_q     <= '0;
      dir_q      <= '0;
      rr_q       <= '0;
      idx_q      <= '0;
      ltp_q      <= 1'b0;
      for (int i = 0; i < NUM_SYN; i++) begin
        pre_age_q[i] <= AGE_MAX;
        w_q[i]       <= '0;
      end
    end else begin
      st_q       <= st_d;
      post_age_q <= post_age_d;
      pend_q     <= pend_d;
      dir_q      <= dir_d;
      rr_q       <= rr_d;
      idx_q      <= idx_d;
      ltp_q      <= ltp_d;
      for (int i = 0; i < NUM_SYN; i++) begin
        pre_age_q[i] <= pre_age_d[i];
        w_q[i]       <= w_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SYN; g++) begin : g_bus
    assign bus.weight_bus[g*W_W +: W_W] = w_q[g];
  end

  assign bus.upd_valid = (st_q == S_UPDATE);
  assign bus.upd_idx   = idx_q;
  assign bus.upd_ltp   = ltp_q;
  assign bus.busy      = (|pend_q) || (st_q == S_UPDATE);

endmodule

// File: tb/tb_stdp_scheduler.sv
// Bench for stdp_scheduler: directed scenarios plus random spikes,
// checked every cycle against a behavioural pending-queue model.
module tb_stdp_scheduler;

  localparam int N    = 4;
  localparam int WIN  = 8;
  localparam int DELW = 12;
  localparam int AMAX = 15;
  localparam int WMAX = 65535;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stdp_scheduler_if bus ();

  stdp_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  int m_w [N];
  int m_pre [N];
  int m_post;
  bit m_pend [N];
  bit m_dir [N];
  int m_rr;
  int m_svc;
  bit m_ltp;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_w[i] = 0;
      m_pre[i] = AMAX;
      m_pend[i] = 0;
      m_dir[i] = 0;
    end
    m_post = AMAX;
    m_rr = 0;
    m_svc = -1;
    m_ltp = 0;
  endtask

  task automatic m_step(input logic [N-1:0] pre, input logic post,
                        input logic le);
    bit rq [N];
    bit rl [N];
    bit got;
    int j;
    for (int i = 0; i < N; i++) begin
      rq[i] = 0;
      rl[i] = 0;
      if (le) begin
        if (pre[i] && m_post < WIN) begin
          rq[i] = 1;
        end else if (post && m_pre[i] < WIN) begin
          rq[i] = 1;
          rl[i] = 1;
        end
      end
    end
    if (m_svc >= 0) begin
      if (m_ltp)
        m_w[m_svc] = (m_w[m_svc] + DELW > WMAX) ? WMAX : m_w[m_svc] + DELW;
      else
        m_w[m_svc] = (m_w[m_svc] < DELW) ? 0 : m_w[m_svc] - DELW;
      m_pend[m_svc] = 0;
      m_rr = (m_svc + 1) % N;
      m_svc = -1;
    end else begin
      got = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (!got && m_pend[j]) begin
          got = 1;
          m_svc = j;
          m_ltp = m_dir[j];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rq[i]) begin
        m_pend[i] = 1;
        m_dir[i] = rl[i];
      end
      m_pre[i] = pre[i] ? 0 : (m_pre[i] < AMAX ? m_pre[i] + 1 : AMAX);
    end
    m_post = post ? 0 : (m_post < AMAX ? m_post + 1 : AMAX);
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] eb;
    bit eb_busy;
    eb = '0;
    eb_busy = (m_svc >= 0);
    for (int i = 0; i < N; i++) begin
      eb[i*16 +: 16] = m_w[i][15:0];
      if (m_pend[i])
        eb_busy = 1;
    end
    chk({tag, ":weights"}, bus.weight_bus, eb);
    chk({tag, ":upd_valid"}, 64'(bus.upd_valid), 64'(m_svc >= 0));
    chk({tag, ":busy"}, 64'(bus.busy), 64'(eb_busy));
    if (m_svc >= 0) begin
      chk({tag, ":upd_idx"}, 64'(bus.upd_idx), 64'(m_svc));
      chk({tag, ":upd_ltp"}, 64'(bus.upd_ltp), 64'(m_ltp));
    end
  endtask

  task automatic step(input logic [N-1:0] pre, input logic post,
                      input string tag);
    bus.preSpike = pre;
    bus.postSpike = post;
    @(posedge clk);
    m_step(pre, post, bus.learn_en);
    #1;
    check_outputs(tag);
    bus.preSpike = '0;
    bus.postSpike = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++)
      step('0, 1'b0, tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ":rst_weights"}, bus.weight_bus, 64'h0);
    chk({tag, ":rst_valid"}, 64'(bus.upd_valid), 64'h0);
    chk({tag, ":rst_idx"}, 64'(bus.upd_idx), 64'h0);
    chk({tag, ":rst_ltp"}, 64'(bus.upd_ltp), 64'h0);
    chk({tag, ":rst_busy"}, 64'(bus.busy), 64'h0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    m_reset();
    check_reset_state(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic burst(input string tag);
    step(4'hF, 1'b0, tag);
    step('0, 1'b0, tag);
    step('0, 1'b1, tag);
    for (int k = 0; k < 8; k++) begin
      step('0, 1'b0, tag);
      if (k % 2 == 0) begin
        chk({tag, ":rr_valid"}, 64'(bus.upd_valid), 64'h1);
        chk({tag, ":rr_idx"}, 64'(bus.upd_idx), 64'(k / 2));
      end else begin
        chk({tag, ":rr_gap"}, 64'(bus.upd_valid), 64'h0);
      end
    end
  endtask

  initial begin
    bus.preSpike = '0;
    bus.postSpike = 1'b0;
    bus.learn_en = 1'b1;
    do_reset("init");

    // LTP: pre at edge 0, post at edge 3
    step(4'b0001, 1'b0, "ltp");
    idle(2, "ltp");
    step('0, 1'b1, "ltp");
    step('0, 1'b0, "ltp");
    chk("ltp:valid", 64'(bus.upd_valid), 64'h1);
    chk("ltp:idx", 64'(bus.upd_idx), 64'h0);
    chk("ltp:dir", 64'(bus.upd_ltp), 64'h1);
    step('0, 1'b0, "ltp");
    chk("ltp:w0", 64'(bus.weight_bus[15:0]), 64'd12);
    chk("ltp:done", 64'(bus.upd_valid), 64'h0);

    // LTD clamps at zero
    idle(20, "ltd");
    step('0, 1'b1, "ltd");
    step('0, 1'b0, "ltd");
    step(4'b0100, 1'b0, "ltd");
    step('0, 1'b0, "ltd");
    chk("ltd:valid", 64'(bus.upd_valid), 64'h1);
    chk("ltd:idx", 64'(bus.upd_idx), 64'h2);
    chk("ltd:dir", 64'(bus.upd_ltp), 64'h0);
    step('0, 1'b0, "ltd");
    chk("ltd:w2", 64'(bus.weight_bus[47:32]), 64'h0);
    idle(20, "ltd0");
    step('0, 1'b1, "ltd0");
    step('0, 1'b0, "ltd0");
    step(4'b0001, 1'b0, "ltd0");
    idle(2, "ltd0");
    chk("ltd0:w0", 64'(bus.weight_bus[15:0]), 64'h0);

    // Window edge: age 7 pairs, age 8 does not
    idle(20, "win7");
    step(4'b0001, 1'b0, "win7");
    idle(7, "win7");
    step('0, 1'b1, "win7");
    chk("win7:busy", 64'(bus.busy), 64'h1);
    idle(3, "win7");
    chk("win7:w0", 64'(bus.weight_bus[15:0]), 64'd12);
    idle(20, "win8");
    step(4'b0001, 1'b0, "win8");
    idle(8, "win8");
    step('0, 1'b1, "win8");
    chk("win8:busy", 64'(bus.busy), 64'h0);
    step('0, 1'b0, "win8");
    chk("win8:valid", 64'(bus.upd_valid), 64'h0);

    // Round robin, twice
    do_reset("rr");
    burst("rr1");
    chk("rr1:weights", bus.weight_bus, 64'h000C_000C_000C_000C);
    idle(20, "rr2");
    burst("rr2");
    chk("rr2:weights", bus.weight_bus, 64'h0018_0018_0018_0018);

    // Coincident spikes give LTD, then an LTP lands on the service edge
    idle(20, "ovw");
    step('0, 1'b1, "ovw");
    step('0, 1'b0, "ovw");
    step(4'b0010, 1'b1, "ovw");
    step('0, 1'b0, "ovw");
    chk("ovw:ltd_idx", 64'(bus.upd_idx), 64'h1);
    chk("ovw:ltd_dir", 64'(bus.upd_ltp), 64'h0);
    step('0, 1'b1, "ovw");
    chk("ovw:w1", 64'(bus.weight_bus[31:16]), 64'd12);
    chk("ovw:busy", 64'(bus.busy), 64'h1);
    step('0, 1'b0, "ovw");
    chk("ovw:ltp_valid", 64'(bus.upd_valid), 64'h1);
    chk("ovw:ltp_dir", 64'(bus.upd_ltp), 64'h1);
    step('0, 1'b0, "ovw");
    chk("ovw:w1b", 64'(bus.weight_bus[31:16]), 64'd24);

    // Saturation at WMAX
    do_reset("sat");
    for (int it = 0; it < 2000 && m_w[0] < WMAX; it++) begin
      step(4'b0001, 1'b0, "sat");
      for (int p = 0; p < 7; p++)
        step('0, 1'b1, "sat");
      idle(8, "sat");
    end
    chk("sat:w0", 64'(bus.weight_bus[15:0]), 64'hFFFF);

    // learn_en low ignores pairings
    idle(20, "noen");
    bus.learn_en = 1'b0;
    step(4'b0001, 1'b0, "noen");
    step('0, 1'b1, "noen");
    step('0, 1'b1, "noen");
    step(4'b0010, 1'b0, "noen");
    step('0, 1'b0, "noen");
    chk("noen:busy", 64'(bus.busy), 64'h0);
    chk("noen:valid", 64'(bus.upd_valid), 64'h0);
    bus.learn_en = 1'b1;

    // Reset while an update is in flight
    idle(20, "rstmid");
    step(4'b0100, 1'b0, "rstmid");
    step('0, 1'b1, "rstmid");
    step('0, 1'b0, "rstmid");
    chk("rstmid:valid", 64'(bus.upd_valid), 64'h1);
    #3;
    do_reset("rstmid");
    idle(6, "rstpost");
    chk("rstpost:busy", 64'(bus.busy), 64'h0);

    // Random spikes
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] pr;
      for (int i = 0; i < N; i++)
        pr[i] = ($urandom_range(0, 5) == 0);
      bus.learn_en = ($urandom_range(0, 9) != 0);
      step(pr, $urandom_range(0, 4) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stdp_scheduler.md
# stdp_scheduler

Learning controller for a bank of NUM_SYN synapses sharing one weight-update datapath. It timestamps pre- and post-synaptic spikes with saturating age counters and classifies each pairing inside the learning window as potentiation (LTP) or depression (LTD). It queues one pending update per synapse and applies the queued updates one at a time through a round-robin arbiter. The block owns the weight registers and drives the weight bus read by the downstream synapse outputs.

## Interface
- NUM_SYN, 4: number of synapses; must be ≥2.
- IDX_W, 2: index width; equals $clog2(NUM_SYN).
- W_W, 16: weight width (unsigned).
- AGE_W, 4: spike-age counter width.
- WIN, 8: learning window; pairing valid when age < WIN; 1 ≤ WIN ≤ 2^AGE_W−1.
- DELW, 12: weight step per update.
- WMAX, 16'hFFFF: upper weight clamp.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- preSpike  in  NUM_SYN  per-synapse pre spike; one-cycle pulses, sampled each edge.
- postSpike  in  1  post-neuron spike, sampled each edge.
- learn_en  in  1  learning enable; when low, new pairings are not captured.
- weight_bus  out  NUM_SYN*W_W  weight of synapse i at bits [i*W_W +: W_W].
- upd_valid  out  1  high for exactly the cycle in which the datapath is in UPDATE.
- upd_idx  out  IDX_W  synapse being updated; valid with upd_valid.
- upd_ltp  out  1  1 = increment, 0 = decrement; valid with upd_valid.
- busy  out  1  any pending flag set, or FSM in UPDATE.

## Operation
- **Reset (asynchronous, reset=0):**
  - all weights = 0; pre_age[i] = post_age = 2^AGE_W−1 (saturated, meaning "no recent spike").
  - pending, dir and rr_ptr are cleared; FSM = IDLE.
  - all outputs are 0 and take effect immediately.
  - Reset mid-update discards the update.
- **Age counters, each edge:**
  - pre_age[i]: if preSpike[i], set to 0; else increment, saturating at 2^AGE_W−1.
  - post_age: same rule, driven by postSpike.
- **Pairing:** uses register values held before the same edge updates them. Evaluated only when learn_en=1.
  - Per synapse, first check: preSpike[i] && post_age < WIN → request LTD.
  - Else check: postSpike && pre_age[i] < WIN → request LTP.
  - If preSpike[i] and postSpike arrive together, the result is LTD (equal timing means depression).
- **Request capture:** on a request, pending[i] ← 1 and dir[i] ← ltp.
  - A newer request overwrites dir of an already-pending entry.
  - If a request lands on the same edge that services entry i, the new request wins: pending stays 1 with the new dir.
- **FSM:**
  - IDLE: if any pending, grant = first pending index searching rr_ptr, rr_ptr+1, … mod NUM_SYN. Latch grant and dir into upd_idx and upd_ltp; go to UPDATE.
  - UPDATE: at the next edge:
    - weight[grant] ← LTP ? min(w+DELW, WMAX) : max(w−DELW, 0);
    - clear pending[grant], unless a new request arrives on that edge;
    - rr_ptr ← grant+1 mod NUM_SYN;
    - return to IDLE.
- **Arithmetic:** use a W_W+1-bit intermediate for the add and the subtract; clamp without wrap-around.
- **learn_en=0:** no new requests are captured. Already-pending entries are still serviced. Age counters keep running.

## Timing
- Request registered at edge E → UPDATE during cycle E+1..E+2 (upd_valid high) → new weight visible on weight_bus after edge E+2.
- Throughput: one update per 2 cycles. N simultaneous requests complete after 2N cycles.
- Fairness: each pending synapse is serviced within 2·NUM_SYN cycles.
- Outputs are registered. busy drops the cycle after the last UPDATE, provided no new request arrived.
- Example timing: preSpike[0] sampled at edge 0, postSpike at edge 3 → pre_age[0]=2 at edge 3 → LTP requested.

## Test plan
- **Reset then LTP:** reset, then preSpike[0] at edge 0 and postSpike at edge 3.
  - Required: upd_valid one cycle, upd_idx=0, upd_ltp=1.
  - Required: weight[0]=12 after edge 5.
- **LTD and clamp at 0:** postSpike at edge 0, preSpike[2] at edge 2.
  - Required: one LTD update with upd_idx=2.
  - Required: weight[2] stays 0 (clamped). After a prior LTP, the weight returns to 0.
- **Window boundary:** pre-to-post gap giving pre_age=7 → LTP occurs. Gap giving pre_age=8 → no request; busy stays 0.
- **Round-robin:** preSpike=4'b1111 at edge 0, postSpike at edge 2.
  - Required: four LTP updates with upd_idx sequence 0,1,2,3, upd_valid every other cycle.
  - Required: all weights = 12.
  - Repeat: the next burst starts at index 0, since rr_ptr wrapped.
- **Simultaneous and overwrite:** preSpike[1] and postSpike on the same edge, with a recent post → LTD.
  - Then an LTP request for synapse 1 on its service edge → pending stays set and a second update runs with upd_ltp=1.
- **Saturation, learn_en, reset mid-op:**
  - Preload near WMAX via repeated LTP → weight saturates at 16'hFFFF.
  - learn_en=0 with valid pairings → no updates.
  - reset asserted during UPDATE → weights 0 and upd_valid 0 immediately; no update after release.
